// File: rtl/score_tracker.sv
// Multi-player score tracker: debounced answer key, saturating per-player counters,
// sequential percentage divider, and a six-digit seven-segment view of one player.
module score_tracker #(
    parameter  int NUM_PLAYERS     = 2,
    parameter  int MAX_COUNT       = 99,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int PW              = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          input_key,
    input  logic          exist,
    input  logic [PW-1:0] player_sel,
    input  logic [PW-1:0] view_player,
    input  logic [2:0]    display_state,
    output logic [6:0]    hex5,
    output logic [6:0]    hex4,
    output logic [6:0]    hex3,
    output logic [6:0]    hex2,
    output logic [6:0]    hex1,
    output logic [6:0]    hex0,
    output logic [6:0]    correct,
    output logic [6:0]    incorrect,
    output logic [6:0]    percent,
    output logic          busy,
    output logic          overrun
);
    localparam int          DW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW:0] NP   = (PW + 1)'(NUM_PLAYERS);
    localparam logic [6:0]  MAX7 = 7'(MAX_COUNT);

    typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

    state_t                         state;
    logic                           sync1, sync2, filt, filt_d;
    logic [DW-1:0]                  db_cnt;
    logic [NUM_PLAYERS-1:0][6:0]    cor_q, inc_q, pct_q;
    logic                           pend_vld, pend_e;
    logic [PW-1:0]                  pend_p, cur_p;
    logic [13:0]                    dvd_q;
    logic [7:0]                     dvs_q, rem_q;
    logic [6:0]                     quo_q;
    logic [2:0]                     step_q;

    logic          strobe, press, start, st_e;
    logic [PW-1:0] st_p;
    logic [6:0]    c_old, i_old, c_new, i_new;
    logic [8:0]    trial;
    logic          fits;

    assign strobe = filt_d & ~filt;
    assign press  = strobe && ({1'b0, player_sel} < NP);

    // A finishing division hands straight over to the queued press, or to a fresh one.
    always_comb begin
        start = 1'b0;
        st_p  = player_sel;
        st_e  = exist;
        case (state)
            IDLE:  start = press;
            WRITE: begin
                if (pend_vld) begin
                    start = 1'b1;
                    st_p  = pend_p;
                    st_e  = pend_e;
                end else begin
                    start = press;
                end
            end
            default: start = 1'b0;
        endcase
        c_old = cor_q[st_p];
        i_old = inc_q[st_p];
        c_new = (st_e && c_old != MAX7) ? c_old + 7'd1 : c_old;
        i_new = (!st_e && i_old != MAX7) ? i_old + 7'd1 : i_old;
    end

    assign trial = {rem_q, quo_q[6]};
    assign fits  = trial >= {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            filt     <= 1'b1;
            filt_d   <= 1'b1;
            db_cnt   <= '0;
            state    <= IDLE;
            cor_q    <= '0;
            inc_q    <= '0;
            pct_q    <= '0;
            pend_vld <= 1'b0;
            pend_e   <= 1'b0;
            pend_p   <= '0;
            cur_p    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            step_q   <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            sync1  <= input_key;
            sync2  <= sync1;
            filt_d <= filt;
            if (sync2 != filt) begin
                if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    filt   <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end

            case (state)
                CALC: begin
                    // Step 0 aligns the remainder; steps 1..7 each yield one quotient bit.
                    if (step_q == 3'd0) begin
                        rem_q <= {1'b0, dvd_q[13:7]};
                        quo_q <= dvd_q[6:0];
                    end else begin
                        rem_q <= fits ? 8'(trial - {1'b0, dvs_q}) : trial[7:0];
                        quo_q <= {quo_q[5:0], fits};
                    end
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd7) state <= WRITE;
                    if (press) begin
                        if (!pend_vld) begin
                            pend_vld <= 1'b1;
                            pend_p   <= player_sel;
                            pend_e   <= exist;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    pct_q[cur_p] <= quo_q;
                    state        <= IDLE;
                    busy         <= 1'b0;
                    if (pend_vld) begin
                        pend_vld <= 1'b0;
                        if (press) overrun <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (start) begin
                cor_q[st_p] <= c_new;
                inc_q[st_p] <= i_new;
                dvd_q       <= 14'(c_new) * 14'd100;
                dvs_q       <= 8'(c_new) + 8'(i_new);
                cur_p       <= st_p;
                step_q      <= 3'd0;
                state       <= CALC;
                busy        <= 1'b1;
            end
        end
    end

    logic view_ok;
    assign view_ok   = {1'b0, view_player} < NP;
    assign correct   = view_ok ? cor_q[view_player] : 7'd0;
    assign incorrect = view_ok ? inc_q[view_player] : 7'd0;
    assign percent   = view_ok ? pct_q[view_player] : 7'd0;

    // Digit codes above 9 (the "10" tens of 100 %) fall through to blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic blank;
    assign blank = display_state != 3'd0;
    assign hex5  = blank ? 7'h7f : seg7(4'(correct / 7'd10));
    assign hex4  = blank ? 7'h7f : seg7(4'(correct % 7'd10));
    assign hex3  = blank ? 7'h7f : seg7(4'(incorrect / 7'd10));
    assign hex2  = blank ? 7'h7f : seg7(4'(incorrect % 7'd10));
    assign hex1  = blank ? 7'h7f : seg7(4'(percent / 7'd10));
    assign hex0  = blank ? 7'h7f : seg7(4'(percent % 7'd10));
endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: main instance with DEBOUNCE_CYCLES=4, plus a
// DEBOUNCE_CYCLES=2 instance fast enough to fill the pending slot and overrun it.
module tb_score_tracker;
    logic       clk = 1'b0;
    logic       reset, input_key, exist, player_sel, view_player;
    logic [2:0] display_state;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0, correct, incorrect, percent;
    logic       busy, overrun;
    logic [6:0] f_hex5, f_hex4, f_hex3, f_hex2, f_hex1, f_hex0, f_cor, f_inc, f_pct;
    logic       f_busy, f_ovr;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000, BL = 7'b1111111;

    int total = 0, passed = 0;

    score_tracker #(.NUM_PLAYERS(2), .MAX_COUNT(99), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .input_key(input_key), .exist(exist),
        .player_sel(player_sel), .view_player(view_player), .display_state(display_state),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .correct(correct), .incorrect(incorrect), .percent(percent),
        .busy(busy), .overrun(overrun));

    score_tracker #(.NUM_PLAYERS(2), .MAX_COUNT(99), .DEBOUNCE_CYCLES(2)) dut_fast (
        .clk(clk), .reset(reset), .input_key(input_key), .exist(exist),
        .player_sel(player_sel), .view_player(view_player), .display_state(display_state),
        .hex5(f_hex5), .hex4(f_hex4), .hex3(f_hex3), .hex2(f_hex2), .hex1(f_hex1), .hex0(f_hex0),
        .correct(f_cor), .incorrect(f_inc), .percent(f_pct),
        .busy(f_busy), .overrun(f_ovr));

    always #5 clk = ~clk;

    task automatic do_press(input logic e, input logic p);
        exist = e; player_sel = p; input_key = 1'b0;
        repeat (8) @(negedge clk);
        input_key = 1'b1;
        repeat (14) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1; input_key = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; input_key = 1'b1; exist = 1'b0; player_sel = 1'b0;
        view_player = 1'b0; display_state = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if ({correct, incorrect, percent} !== 21'd0)
            $display("FAIL reset_stats: got %0d/%0d/%0d expected 0/0/0", correct, incorrect, percent); else passed++;
        total++; if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {S0, S0, S0, S0, S0, S0})
            $display("FAIL reset_hex: got %h expected %h", {hex5, hex4, hex3, hex2, hex1, hex0}, {S0, S0, S0, S0, S0, S0}); else passed++;
        total++; if ({busy, overrun} !== 2'b00)
            $display("FAIL reset_flags: got busy=%0b overrun=%0b expected 0 0", busy, overrun); else passed++;
    endtask

    task automatic test_correct_latency();
        int n = 0;
        exist = 1'b1; player_sel = 1'b0; input_key = 1'b0;
        while (correct == 7'd0 && n < 20) begin @(negedge clk); n++; end
        total++; if (correct !== 7'd1)
            $display("FAIL press_correct: got correct=%0d expected 1 within 20 cycles", correct); else passed++;
        total++; if ({incorrect, percent, busy} !== {7'd0, 7'd0, 1'b1})
            $display("FAIL press_start: got inc=%0d pct=%0d busy=%0b expected 0 0 1", incorrect, percent, busy); else passed++;
        repeat (8) @(negedge clk);
        total++; if (percent !== 7'd0 || busy !== 1'b1)
            $display("FAIL pct_early: got pct=%0d busy=%0b expected 0 1 at edge 8", percent, busy); else passed++;
        @(negedge clk);
        total++; if (percent !== 7'd100 || busy !== 1'b0)
            $display("FAIL pct_latency: got pct=%0d busy=%0b expected 100 0 at edge 9", percent, busy); else passed++;
        total++; if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {S0, S1, S0, S0, BL, S0})
            $display("FAIL hex_100: got %h expected %h", {hex5, hex4, hex3, hex2, hex1, hex0}, {S0, S1, S0, S0, BL, S0}); else passed++;
        input_key = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_incorrect();
        do_press(1'b0, 1'b0);
        total++; if ({correct, incorrect, percent} !== {7'd1, 7'd1, 7'd50})
            $display("FAIL incorrect_stats: got %0d/%0d/%0d expected 1/1/50", correct, incorrect, percent); else passed++;
        total++; if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {S0, S1, S0, S1, S5, S0})
            $display("FAIL hex_50: got %h expected %h", {hex5, hex4, hex3, hex2, hex1, hex0}, {S0, S1, S0, S1, S5, S0}); else passed++;
        view_player = 1'b1; #1;
        total++; if ({correct, incorrect, percent} !== 21'd0)
            $display("FAIL player1_idle: got %0d/%0d/%0d expected 0/0/0", correct, incorrect, percent); else passed++;
        view_player = 1'b0;
    endtask

    task automatic test_glitch();
        exist = 1'b1; input_key = 1'b0;
        repeat (3) @(negedge clk);
        input_key = 1'b1;
        repeat (15) @(negedge clk);
        total++; if ({correct, incorrect, percent, busy} !== {7'd1, 7'd1, 7'd50, 1'b0})
            $display("FAIL glitch: got %0d/%0d/%0d busy=%0b expected 1/1/50 0", correct, incorrect, percent, busy); else passed++;
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        player_sel = 1'b0; view_player = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 9) begin
                total++; if ({f_cor, f_inc} !== {7'd1, 7'd0})
                    $display("FAIL queued_hold: got %0d/%0d expected 1/0", f_cor, f_inc); else passed++;
            end
            if (i == 14) begin
                total++; if ({f_inc, f_pct, f_ovr, f_busy} !== {7'd1, 7'd100, 1'b1, 1'b1})
                    $display("FAIL dequeue: got inc=%0d pct=%0d ovr=%0b busy=%0b expected 1 100 1 1", f_inc, f_pct, f_ovr, f_busy); else passed++;
            end
            input_key = (i < 12) ? ((i % 4) >= 2) : 1'b1;
            exist     = (i < 6);
        end
        repeat (12) @(negedge clk);
        total++; if ({f_cor, f_inc, f_pct} !== {7'd1, 7'd1, 7'd50})
            $display("FAIL two_presses: got %0d/%0d/%0d expected 1/1/50", f_cor, f_inc, f_pct); else passed++;
        total++; if ({f_ovr, f_busy} !== 2'b10)
            $display("FAIL overrun_sticky: got ovr=%0b busy=%0b expected 1 0", f_ovr, f_busy); else passed++;
        total++; if ({correct, incorrect} !== 14'd0)
            $display("FAIL short_pulses: got %0d/%0d expected 0/0", correct, incorrect); else passed++;
    endtask

    task automatic test_saturation();
        int n = 0;
        pulse_reset();
        view_player = 1'b1;
        do_press(1'b0, 1'b1);
        repeat (99) do_press(1'b1, 1'b1);
        total++; if ({correct, incorrect, percent} !== {7'd99, 7'd1, 7'd99})
            $display("FAIL preload: got %0d/%0d/%0d expected 99/1/99", correct, incorrect, percent); else passed++;
        total++; if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {S9, S9, S0, S1, S9, S9})
            $display("FAIL hex_99: got %h expected %h", {hex5, hex4, hex3, hex2, hex1, hex0}, {S9, S9, S0, S1, S9, S9}); else passed++;
        exist = 1'b1; input_key = 1'b0;
        while (busy == 1'b0 && n < 20) begin @(negedge clk); n++; end
        total++; if (busy !== 1'b1)
            $display("FAIL sat_recompute: got busy=%0b expected 1 within 20 cycles", busy); else passed++;
        input_key = 1'b1;
        repeat (20) @(negedge clk);
        total++; if ({correct, incorrect, percent, busy} !== {7'd99, 7'd1, 7'd99, 1'b0})
            $display("FAIL saturate: got %0d/%0d/%0d busy=%0b expected 99/1/99 0", correct, incorrect, percent, busy); else passed++;
        view_player = 1'b0; #1;
        total++; if ({correct, incorrect, percent} !== 21'd0)
            $display("FAIL player0_idle: got %0d/%0d/%0d expected 0/0/0", correct, incorrect, percent); else passed++;
    endtask

    task automatic test_reset_mid_calc();
        int n = 0;
        exist = 1'b1; player_sel = 1'b0; view_player = 1'b0; input_key = 1'b0;
        while (correct == 7'd0 && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b1)
            $display("FAIL mid_calc_busy: got busy=%0b expected 1", busy); else passed++;
        reset = 1'b1; input_key = 1'b1;
        @(negedge clk);
        total++; if ({correct, incorrect, percent, busy, overrun} !== 23'd0)
            $display("FAIL reset_abort: got %0d/%0d/%0d busy=%0b ovr=%0b expected all 0", correct, incorrect, percent, busy, overrun); else passed++;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        total++; if ({correct, percent, busy} !== 15'd0)
            $display("FAIL reset_no_pending: got cor=%0d pct=%0d busy=%0b expected 0 0 0", correct, percent, busy); else passed++;
    endtask

    task automatic test_display_blank();
        do_press(1'b1, 1'b0);
        display_state = 3'd3; #1;
        total++; if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {BL, BL, BL, BL, BL, BL})
            $display("FAIL blank: got %h expected %h", {hex5, hex4, hex3, hex2, hex1, hex0}, {BL, BL, BL, BL, BL, BL}); else passed++;
        display_state = 3'd0; #1;
        total++; if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {S0, S1, S0, S0, BL, S0})
            $display("FAIL unblank: got %h expected %h", {hex5, hex4, hex3, hex2, hex1, hex0}, {S0, S1, S0, S0, BL, S0}); else passed++;
    endtask

    initial begin
        test_reset();
        test_correct_latency();
        test_incorrect();
        test_glitch();
        test_back_to_back();
        test_saturation();
        test_reset_mid_calc();
        test_display_blank();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
- Multi-player successor to the memory-game score display.
- Debounces the answer pushbutton and credits each press to a selected player as correct or incorrect.
- Computes each player's success percentage with a multi-cycle sequential divider, using the post-update counts.
- Drives six active-low seven-segment digits for the player chosen by view_player.

Parameters:
NUM_PLAYERS, 2, number of independent score channels (1..8)
MAX_COUNT, 99, saturation value for correct/incorrect counters (≤99, two-digit display)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a key level change (≥2)

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high; clears all state
input_key  input  1  raw pushbutton, active-low, asynchronous to clk
exist  input  1  sampled with a press: 1 = correct answer, 0 = incorrect
player_sel  input  PW  player credited by a press, PW = max(1,$clog2(NUM_PLAYERS))
view_player  input  PW  player shown on outputs/hex
display_state  input  3  0 = show digits, any other value = blank all digits
hex5..hex0  output  7 each  active-low segments: correct tens/units, incorrect tens/units, percent tens/units
correct, incorrect, percent  output  7 each  registered stats of view_player
busy  output  1  divider running
overrun  output  1  sticky: a press was dropped

Behaviour:
- Reset: all counters and percents 0; filtered key level 1; pending empty; busy 0; overrun 0; FSM IDLE.
- Reset also aborts any division in progress and clears the pending press.
- Input path: 2-flop synchroniser, then debounce counter. The filtered level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
- Press strobe: one cycle, on filtered 1→0. The cycle it asserts is cycle E, in which exist and player_sel are sampled.
- Player range: player_sel ≥ NUM_PLAYERS ignores the press entirely.
- FSM states: IDLE, CALC, WRITE.
- IDLE + strobe, at end of E:
  - Increment correct[p] if exist=1, else incorrect[p].
  - Counters saturate at MAX_COUNT and hold.
  - Latch dividend = new_correct*100 (14b) and divisor = new_correct+new_incorrect (8b, always ≥1).
  - Go to CALC; busy=1.
- CALC: 7 restoring-division iterations, one per cycle, producing a 7-bit quotient (truncated, max 100). Then WRITE.
- WRITE: percent[p] ← quotient. If pending is valid, behave as IDLE+strobe with the pending press (pending cleared), else go to IDLE with busy=0.
- Latency: percent[p] is visible on the clock edge 9 edges after the end of E. Counter outputs are visible after end of E.
- Strobe while busy:
  - Pending empty: store {player_sel, exist}; counters are not updated until it is dequeued.
  - Pending full: press dropped, overrun ← 1 (sticky until reset).
  - Strobe in the WRITE cycle with pending empty: it is stored and serviced immediately.
- Saturated press: counter unchanged, but a full recompute still runs (same result).
- View outputs:
  - correct/incorrect/percent = registered arrays indexed by view_player.
  - view_player ≥ NUM_PLAYERS outputs 0.
  - Changing view_player takes effect combinationally from the registers.
- Hex outputs:
  - Digits = value/10 and value%10, standard active-low 0–9 encoding (0 = 7'b1000000).
  - Percent 100 displays as "10" tens/units: tens digit 10 shows blank, units shows 0.
  - display_state≠0 forces all digits to 7'b1111111.

Test Plan:
- DEBOUNCE_CYCLES=4; reset 2 cycles → all stats 0, hex shows 00 00 00, busy=0, overrun=0.
- Player 0, exist=1, key low 10 cycles → correct=1, incorrect=0, percent=100 exactly 9 edges after strobe; hex1 blank, hex0="0".
- Then exist=0 press on player 0 → incorrect=1, percent=50; player 1 stats stay 0 throughout (view_player=1 shows 0/0/0).
- Key low for 3 cycles, then high (glitch) → no strobe, no counter change.
- Three presses spaced so the second and third arrive while busy → second queued and applied after first WRITE; third dropped, overrun=1. Final counts reflect exactly two presses.
- Preload 99 correct via presses, press correct again → correct stays 99, percent recomputed.
- Reset asserted mid-CALC → next cycle all zero, busy=0, pending empty.
- display_state=3 → all hex = 7'b1111111.
